// File: rtl/fc_skew_feeder.sv
// Skewing feeder for the left edge of a systolic PE array: row r sees each
// accepted column 1+r cycles after acceptance, with a done pulse per vector.
module fc_skew_feeder #(
  parameter int ROWS = 3,
  parameter int DW   = 8,
  parameter int LEN  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DW-1:0]         in_data,
  input  logic                       in_last,
  output logic [ROWS*DW-1:0]         out_data,
  output logic [ROWS-1:0]            out_start,
  output logic                       done,
  output logic [$clog2(LEN+1)-1:0]   vec_len
);

  localparam int CW  = $clog2(LEN+1);
  localparam int DRW = (ROWS > 1) ? $clog2(ROWS+1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [DRW-1:0]  drain_cnt;
  logic [CW-1:0]   cnt_inc;
  logic            accept;
  logic            final_beat;
  logic [ROWS-1:0] last_sr;
  logic            done_next;

  // Handshake: a beat transfers only in a cycle with in_valid && in_ready;
  // in_ready never depends on in_valid, and is low during DRAIN and reset.
  assign in_ready   = ~reset && (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign cnt_inc    = beat_cnt + 1'b1;
  assign final_beat = accept && (in_last || (cnt_inc == CW'(LEN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            beat_cnt <= cnt_inc;
            if (final_beat) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          // Hold the input closed until the last row has emitted the vector.
          if (drain_cnt == DRW'(ROWS-1)) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          beat_cnt  <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Per-row delay lines; a non-accepted cycle enters as a zero bubble.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] d_sr [0:r];
    logic [r:0]    s_sr;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i <= r; i++) begin
          d_sr[i] <= '0;
        end
        s_sr <= '0;
      end else begin
        d_sr[0] <= accept ? in_data[r*DW +: DW] : '0;
        s_sr[0] <= accept;
        for (int i = 1; i <= r; i++) begin
          d_sr[i] <= d_sr[i-1];
          s_sr[i] <= s_sr[i-1];
        end
      end
    end

    assign out_data[r*DW +: DW] = d_sr[r];
    assign out_start[r]         = s_sr[r];
  end

  // The final-beat marker travels alongside the slowest lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sr <= '0;
    end else begin
      last_sr[0] <= final_beat;
      for (int i = 1; i < ROWS; i++) begin
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  if (ROWS == 1) begin : g_done1
    assign done_next = final_beat;
  end else begin : g_donen
    assign done_next = last_sr[ROWS-2];
  end

  assign done = last_sr[ROWS-1];

  // With ROWS==1 the count is captured on the accept edge itself; otherwise
  // beat_cnt is still holding the final count during DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_len <= '0;
    end else if (done_next) begin
      vec_len <= (ROWS == 1) ? cnt_inc : beat_cnt;
    end
  end

endmodule

// File: tb/tb_fc_skew_feeder.sv
// Scoreboard bench for fc_skew_feeder: a cycle-indexed model predicts when each
// lane shows each accepted column and when done/vec_len appear.
module tb_fc_skew_feeder;

  localparam int ROWS = 3;
  localparam int DW   = 8;
  localparam int LEN  = 3;
  localparam int CW   = $clog2(LEN+1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data = '0;
  logic                 in_last = 1'b0;
  logic [ROWS*DW-1:0]   out_data;
  logic [ROWS-1:0]      out_start;
  logic                 done;
  logic [CW-1:0]        vec_len;

  fc_skew_feeder #(.ROWS(ROWS), .DW(DW), .LEN(LEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_data(out_data), .out_start(out_start), .done(done), .vec_len(vec_len)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] at; logic [DW-1:0] data; } lane_exp_t;
  typedef struct packed { logic [31:0] at; logic [CW-1:0] len;  } done_exp_t;

  lane_exp_t lane_q [ROWS][$];
  done_exp_t done_q [$];
  logic [CW-1:0] exp_vec_len = '0;
  bit  mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: beats so far in the open vector, accept cycle of last final beat
  int model_cnt = 0;
  int last_t    = -100;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // driver: one cycle of stimulus; model decides acceptance and schedules outputs
  task automatic step(input logic v, input logic [ROWS*DW-1:0] d, input logic l, output bit acc);
    logic exp_ready;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    exp_ready = !reset && !(cyc > last_t && cyc <= last_t + ROWS);
    chk("in_ready", in_ready, exp_ready);
    acc = v && exp_ready;
    if (reset) begin
      model_cnt = 0;
      last_t    = -100;
    end else if (acc) begin
      model_cnt++;
      for (int r = 0; r < ROWS; r++)
        lane_q[r].push_back(lane_exp_t'{at: 32'(cyc + 1 + r), data: d[r*DW +: DW]});
      if (l || model_cnt == LEN) begin
        done_q.push_back(done_exp_t'{at: 32'(cyc + ROWS), len: CW'(model_cnt)});
        last_t    = cyc;
        model_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, ROWS*DW'($urandom), 1'b0, a);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      for (int r = 0; r < ROWS; r++) begin : lanes
        logic          hit;
        logic [DW-1:0] ed;
        hit = (lane_q[r].size() > 0) && (lane_q[r][0].at == 32'(cyc));
        ed  = hit ? lane_q[r][0].data : '0;
        if (hit) void'(lane_q[r].pop_front());
        chk($sformatf("out_start[%0d]", r), out_start[r], hit);
        chk($sformatf("out_data lane%0d", r), out_data[r*DW +: DW], ed);
      end
      begin : done_chk
        logic dh;
        dh = (done_q.size() > 0) && (done_q[0].at == 32'(cyc));
        if (dh) begin
          exp_vec_len = done_q[0].len;
          void'(done_q.pop_front());
        end
        chk("done", done, dh);
        chk("vec_len", vec_len, exp_vec_len);
      end
      if (reset) begin
        for (int r = 0; r < ROWS; r++) lane_q[r].delete();
        done_q.delete();
        exp_vec_len = '0;
      end
    end
  end

  initial begin
    logic [ROWS*DW-1:0] beats [6];
    bit a;
    int idx;
    int guard;

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(2);                // reset held: all outputs 0, in_ready 0
    reset = 1'b0;

    // full vector ended by LEN, then a second vector with in_valid held high
    beats[0] = 24'h0C0B0A; beats[1] = 24'h1C1B1A; beats[2] = 24'h2C2B2A;
    for (int i = 3; i < 6; i++) beats[i] = 24'($urandom);
    idx = 0; guard = 0;
    while (idx < 6 && guard < 40) begin
      step(1'b1, beats[idx], 1'b0, a);
      if (a) idx++;
      guard++;
    end
    chk("backpressure_vectors_accepted", 32'(idx), 32'd6);
    idle(5);

    // bubble inside RUN
    step(1'b1, 24'h302010, 1'b0, a);
    step(1'b0, 24'hFFFFFF, 1'b0, a);
    step(1'b1, 24'h312111, 1'b0, a);
    step(1'b1, 24'h322212, 1'b0, a);
    idle(5);

    // early last: one-beat vector
    step(1'b1, 24'h555555, 1'b1, a);
    idle(5);

    // reset in the second DRAIN cycle of a full vector
    step(1'b1, 24'h0C0B0A, 1'b0, a);
    step(1'b1, 24'h1C1B1A, 1'b0, a);
    step(1'b1, 24'h2C2B2A, 1'b0, a);
    step(1'b0, 24'h0, 1'b0, a);
    reset = 1'b1;
    step(1'b0, 24'h0, 1'b0, a);
    step(1'b0, 24'h0, 1'b0, a);
    reset = 1'b0;
    step(1'b1, 24'h777777, 1'b1, a);   // in_ready expected 1 right after release
    idle(5);

    // idle hold with garbage on in_data
    idle(10);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      step(($urandom_range(0, 99) < 65), 24'($urandom), ($urandom_range(0, 7) == 0), a);
    end
    reset = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
